// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor
//   Receive side of a VGA link. Rebuilds the pixel column/line counters
//   from the hSync/vSync pins alone. Checks line and frame periods against
//   the configured timing, declares lock after LOCK_FRAMES clean frames,
//   and counts completed frames and timing errors.
//
//   Optional build macro: VGA_FRAME_CRC_EN adds frame_crc, a CRC-16-CCITT
//   over every pixel delivered in a locked frame.
//
// Ports
//   clk          system clock; one pixel lasts CLK_DIV clocks
//   rst          synchronous active-high reset
//   hSync        horizontal sync, active low
//   vSync        vertical sync, active low
//   rgb[11:0]    pixel colour {R,G,B}
//   hCount[9:0]  recovered pixel column (saturates at 1023)
//   vCount[9:0]  recovered line (saturates at 1023)
//   bright       recovered active-video flag
//   pixel_valid  one-clk strobe on the first clock of each active pixel
//                while locked
//   pixel_rgb    rgb captured on the pixel_valid clock
//   locked       timing lock
//   frame_count  frames completed while locked, wraps
//   err_count    timing error events, saturates at 255
//   frame_crc    (VGA_FRAME_CRC_EN only) CRC of the last locked frame
//   dbg_state    FSM state: 0 SEARCH, 1 TRACK, 2 LOCKED
//
// Handshake: pixel_valid/pixel_rgb is a valid-only strobe with no ready.
// The consumer must take pixel_rgb in the cycle pixel_valid is high;
// pixel_rgb holds its value until the next strobe.
module vga_timing_monitor #(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_ACT_START = 35,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [11:0] rgb,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        pixel_valid,
  output logic [11:0] pixel_rgb,
  output logic        locked,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count,
`ifdef VGA_FRAME_CRC_EN
  output logic [15:0] frame_crc,
`endif
  output logic [1:0]  dbg_state
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] CNT_MAX  = 10'd1023;
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_N = 10'(H_SYNC);
  localparam logic [9:0] H_MISS   = 10'(H_TOTAL + 8);
  localparam logic [9:0] H_ACT_LO = 10'(H_ACT_START);
  localparam logic [9:0] H_ACT_HI = 10'(H_ACT_START + H_ACTIVE);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT_LO = 10'(V_ACT_START);
  localparam logic [9:0] V_ACT_HI = 10'(V_ACT_START + V_ACTIVE);
  localparam logic [7:0] LOCK_N   = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             hs_q, hs_d, vs_q, vs_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       hcount_q, hcount_d;
  logic [9:0]       vcount_q, vcount_d;
  logic             bright_q, bright_d;
  logic             pixel_valid_q, pixel_valid_d;
  logic [11:0]      pixel_rgb_q, pixel_rgb_d;
  logic             locked_q, locked_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic [7:0]       err_count_q, err_count_d;
  logic [7:0]       good_q, good_d;

  logic hfall, vfall, hrise, div_last;
  logic err_line, err_sync, err_miss, err_frame, err_valign, err_any;

  always_comb begin
    hs_d  = hSync;
    vs_d  = vSync;
    hfall = hs_q & ~hSync;
    vfall = vs_q & ~vSync;
    hrise = ~hs_q & hSync;
    div_last = (div_q == DIV_LAST);

    // Horizontal: every hSync fall re-phases the pixel divider to the line.
    if (hfall) begin
      hcount_d = '0;
      div_d    = '0;
    end else begin
      div_d    = div_last ? '0 : div_q + DIV_W'(1);
      hcount_d = (div_last && (hcount_q != CNT_MAX)) ? hcount_q + 10'd1 : hcount_q;
    end

    // Vertical: lines are counted on hSync falls only.
    vcount_d = vcount_q;
    if (hfall && vfall) begin
      vcount_d = '0;
    end else if (hfall && (vcount_q != CNT_MAX)) begin
      vcount_d = vcount_q + 10'd1;
    end

    bright_d = (hcount_d >= H_ACT_LO) && (hcount_d < H_ACT_HI) &&
               (vcount_d >= V_ACT_LO) && (vcount_d < V_ACT_HI);

    // Error sources. The sync-width check looks at the count that the
    // rising sample produces: on a correct line that sample is the first
    // clock of pixel H_SYNC.
    err_line   = hfall && ((hcount_q != H_LAST) || !div_last);
    err_sync   = hrise && (hcount_d != H_SYNC_N);
    err_miss   = (hcount_d == H_MISS) && (hcount_q != H_MISS);
    err_frame  = vfall && (vcount_q != V_LAST);
    err_valign = vfall && !hfall;
    err_any    = err_line | err_sync | err_miss | err_frame | err_valign;

    // Lock FSM; errors are only meaningful once a frame start was seen.
    state_d       = state_q;
    good_d        = good_q;
    locked_d      = locked_q;
    frame_count_d = frame_count_q;
    case (state_q)
      ST_SEARCH: begin
        locked_d = 1'b0;
        if (hfall && vfall) begin
          state_d = ST_TRACK;
          good_d  = '0;
        end
      end
      ST_TRACK: begin
        if (err_any) begin
          state_d = ST_SEARCH;
        end else if (vfall) begin
          good_d = good_q + 8'd1;
          if ((good_q + 8'd1) == LOCK_N) begin
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (err_any) begin
          state_d  = ST_SEARCH;
          locked_d = 1'b0;
        end else if (vfall) begin
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      default: begin
        state_d  = ST_SEARCH;
        locked_d = 1'b0;
      end
    endcase

    err_count_d = err_count_q;
    if ((state_q != ST_SEARCH) && err_any && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end

    // Gate with the next lock value so a strobe never accompanies locked=0.
    pixel_valid_d = locked_d && bright_d && (div_d == '0);
    pixel_rgb_d   = pixel_valid_d ? rgb : pixel_rgb_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_SEARCH;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      div_q         <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      bright_q      <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_rgb_q   <= '0;
      locked_q      <= 1'b0;
      frame_count_q <= '0;
      err_count_q   <= '0;
      good_q        <= '0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      div_q         <= div_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      bright_q      <= bright_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_rgb_q   <= pixel_rgb_d;
      locked_q      <= locked_d;
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
      good_q        <= good_d;
    end
  end

  assign hCount      = hcount_q;
  assign vCount      = vcount_q;
  assign bright      = bright_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_rgb   = pixel_rgb_q;
  assign locked      = locked_q;
  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;
  assign dbg_state   = state_q;

`ifdef VGA_FRAME_CRC_EN
  // CRC-16-CCITT, MSB first, one 16-bit word per step.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc_in,
                                             input logic [15:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  logic [15:0] crc_q, crc_d, frame_crc_q, frame_crc_d;

  always_comb begin
    crc_d       = crc_q;
    frame_crc_d = frame_crc_q;
    // Outside lock the running CRC stays at its seed so the first locked
    // frame after (re)lock starts clean.
    if (state_q != ST_LOCKED) begin
      crc_d = 16'hFFFF;
    end else if (vfall) begin
      frame_crc_d = crc_q;
      crc_d       = 16'hFFFF;
    end else if (pixel_valid_q) begin
      crc_d = crc16_step(crc_q, {4'b0000, pixel_rgb_q});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q       <= 16'hFFFF;
      frame_crc_q <= '0;
    end else begin
      crc_q       <= crc_d;
      frame_crc_q <= frame_crc_d;
    end
  end

  assign frame_crc = frame_crc_q;
`endif

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a reduced timing so whole
// frames stay short: 24 pixels/line, 10 lines/frame, 4 clocks/pixel.
module tb_vga_timing_monitor;

  localparam int CLK_DIV     = 4;
  localparam int H_TOTAL     = 24;
  localparam int H_SYNC      = 4;
  localparam int H_ACT_START = 6;
  localparam int H_ACTIVE    = 16;
  localparam int V_TOTAL     = 10;
  localparam int V_ACT_START = 3;
  localparam int V_ACTIVE    = 5;
  localparam int LOCK_FRAMES = 2;
  localparam int V_SYNC      = 2;

  localparam int M_NORMAL = 0;
  localparam int M_LONG   = 1;
  localparam int M_VLATE  = 2;
  localparam int M_RST    = 3;

  logic        clk;
  logic        rst;
  logic        hSync;
  logic        vSync;
  logic [11:0] rgb;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        bright;
  logic        pixel_valid;
  logic [11:0] pixel_rgb;
  logic        locked;
  logic [15:0] frame_count;
  logic [7:0]  err_count;
  logic [1:0]  dbg_state;
`ifdef VGA_FRAME_CRC_EN
  logic [15:0] frame_crc;
`endif

  vga_timing_monitor #(
    .CLK_DIV(CLK_DIV), .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC),
    .H_ACT_START(H_ACT_START), .H_ACTIVE(H_ACTIVE), .V_TOTAL(V_TOTAL),
    .V_ACT_START(V_ACT_START), .V_ACTIVE(V_ACTIVE), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hSync(hSync),
    .vSync(vSync),
    .rgb(rgb),
    .hCount(hCount),
    .vCount(vCount),
    .bright(bright),
    .pixel_valid(pixel_valid),
    .pixel_rgb(pixel_rgb),
    .locked(locked),
    .frame_count(frame_count),
    .err_count(err_count),
`ifdef VGA_FRAME_CRC_EN
    .frame_crc(frame_crc),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int exp_err = 0;
  int pv_cnt = 0;
  bit sb_en = 1'b0;
  logic [11:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] rgb_f(input int p, input int l);
    return 12'(p * 16) ^ 12'(l) ^ 12'h5A0;
  endfunction

  function automatic logic [15:0] crc_model(input logic [15:0] c_in, input logic [15:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  // ---------------- scoreboard: pixel strobes ----------------
  always @(posedge clk) begin
    #2;
    if (pixel_valid) pv_cnt++;
    if (sb_en && pixel_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_extra_pulse: observed strobe at h=%0d v=%0d expected none", hCount, vCount);
      end else begin
        chk("sb_pixel_rgb", {20'd0, pixel_rgb}, {20'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input logic hs, input logic vs, input logic [11:0] c);
    hSync = hs;
    vSync = vs;
    rgb   = c;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_hcount"}, hCount, 0);
    chk({tag, "_vcount"}, vCount, 0);
    chk({tag, "_bright"}, bright, 0);
    chk({tag, "_pixel_valid"}, pixel_valid, 0);
    chk({tag, "_pixel_rgb"}, pixel_rgb, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // One frame of generated timing. lock_exp < 0 skips the lock check on
  // the first clock; pix_chk enables the active-region probes.
  task automatic run_frame(input int mode, input int lock_exp, input bit pix_chk);
    for (int line = 0; line < V_TOTAL; line++) begin
      int plen;
      int line_start;
      bit v_act;
      plen = (mode == M_LONG && line == 4) ? H_TOTAL + 1 : H_TOTAL;
      line_start = pv_cnt;
      v_act = (line >= V_ACT_START) && (line < V_ACT_START + V_ACTIVE);
      for (int p = 0; p < plen; p++) begin
        for (int k = 0; k < CLK_DIV; k++) begin
          logic hs, vs;
          logic [11:0] c;
          bit rst_now;
          hs = (p >= H_SYNC);
          vs = (line >= V_SYNC);
          if (mode == M_VLATE && line == 0 && p == 0 && k == 0) vs = 1'b1;
          c = rgb_f(p, line);
          if (sb_en && v_act && p >= H_ACT_START && p < H_ACT_START + H_ACTIVE && k == 0)
            exp_q.push_back(c);
          rst_now = (mode == M_RST && line == V_ACT_START + 1 && p == H_ACT_START + 3 && k == 1);
          if (rst_now) rst = 1'b1;
          tick(hs, vs, c);
          rst = 1'b0;

          if (line == 0 && p == 0 && k == 0 && lock_exp >= 0)
            chk("lock_at_vfall", locked, lock_exp);

          if (pix_chk && line == V_ACT_START && p == H_ACT_START && k == 0) begin
            chk("first_px_hcount", hCount, H_ACT_START);
            chk("first_px_vcount", vCount, V_ACT_START);
            chk("first_px_bright", bright, 1);
            chk("first_px_valid", pixel_valid, 1);
            chk("first_px_rgb", pixel_rgb, rgb_f(H_ACT_START, V_ACT_START));
          end
          if (pix_chk && line == V_ACT_START && p == H_ACT_START && k == 1)
            chk("px_valid_one_clk", pixel_valid, 0);
          if (pix_chk && line == V_ACT_START && p == H_ACT_START - 1 && k == 0)
            chk("bright_before_col", bright, 0);
          if (pix_chk && p == H_ACT_START && k == 0)
            chk("bright_at_col_first", bright, v_act);
          if (pix_chk && line == V_ACT_START && p == H_ACT_START + H_ACTIVE - 1 && k == 0)
            chk("bright_at_col_last", bright, 1);
          if (pix_chk && line == V_ACT_START && p == H_ACT_START + H_ACTIVE && k == 0)
            chk("bright_after_col", bright, 0);

          if (mode == M_LONG && line == 4 && p == H_TOTAL && k == CLK_DIV - 1) begin
            chk("long_line_hcount", hCount, H_TOTAL);
            chk("long_line_still_locked", locked, 1);
          end
          if (mode == M_LONG && line == 5 && p == 0 && k == 0) begin
            exp_err++;
            chk("long_line_err", err_count, exp_err);
            chk("long_line_unlock", locked, 0);
            chk("long_line_state", dbg_state, 0);
          end

          if (mode == M_VLATE && line == 0 && p == 0 && k == 0)
            chk("vlate_locked_before", locked, 1);
          if (mode == M_VLATE && line == 0 && p == 0 && k == 1) begin
            exp_err++;
            chk("vlate_err", err_count, exp_err);
            chk("vlate_unlock", locked, 0);
            chk("vlate_state", dbg_state, 0);
          end

          if (rst_now) begin
            exp_err = 0;
            check_all_zero("midrst");
          end
        end
      end
      if (pix_chk && line == V_ACT_START)
        chk("pulses_per_line", pv_cnt - line_start, H_ACTIVE);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] crc_exp;
    rst = 1'b1;
    hSync = 1'b1;
    vSync = 1'b1;
    rgb = '0;
    @(negedge clk);
    tick(1'b1, 1'b1, 12'h000);
    tick(1'b1, 1'b1, 12'hFFF);
    check_all_zero("reset");
    rst = 1'b0;

    // Acquire: TRACK at 1st vSync fall, lock at the 3rd.
    run_frame(M_NORMAL, 0, 1'b0);
    chk("frame1_state_track", dbg_state, 1);
    run_frame(M_NORMAL, 0, 1'b0);
    run_frame(M_NORMAL, 1, 1'b0);
    chk("frame3_frame_count", frame_count, 0);

    // Locked frame with pixel probes and scoreboard.
    pv_cnt = 0;
    sb_en = 1'b1;
    run_frame(M_NORMAL, 1, 1'b1);
    sb_en = 1'b0;
    chk("frame4_frame_count", frame_count, 1);
    chk("frame4_err_count", err_count, 0);
    chk("pulses_per_frame", pv_cnt, H_ACTIVE * V_ACTIVE);
    chk("sb_queue_drained", exp_q.size(), 0);

`ifdef VGA_FRAME_CRC_EN
    // Frame 3 was the first locked frame; its CRC is latched at frame 4 start.
    crc_exp = 16'hFFFF;
    for (int l = V_ACT_START; l < V_ACT_START + V_ACTIVE; l++)
      for (int p = H_ACT_START; p < H_ACT_START + H_ACTIVE; p++)
        crc_exp = crc_model(crc_exp, {4'b0000, rgb_f(p, l)});
    chk("frame_crc", frame_crc, crc_exp);
`else
    crc_exp = 16'h0000;
`endif

    // Stretched line: one error, drop lock, relock after two clean frames.
    run_frame(M_LONG, 1, 1'b0);
    chk("long_frame_count", frame_count, 2);
    run_frame(M_NORMAL, 0, 1'b0);
    run_frame(M_NORMAL, 0, 1'b0);
    run_frame(M_NORMAL, 1, 1'b0);
    chk("relock_state", dbg_state, 2);
    chk("relock_err_count", err_count, exp_err);

    // vSync fall one clock after the hSync fall.
    run_frame(M_VLATE, -1, 1'b0);
    run_frame(M_NORMAL, 0, 1'b0);
    chk("after_vlate_state_track", dbg_state, 1);

    // Hold hSync high: counter saturates, missing sync counted once.
    for (int i = 0; i < 4400; i++) tick(1'b1, 1'b1, 12'h000);
    exp_err++;
    chk("miss_hcount_sat", hCount, 1023);
    chk("miss_err_once", err_count, exp_err);
    chk("miss_locked", locked, 0);
    chk("miss_state", dbg_state, 0);

    // Enter TRACK then break the sync width, repeatedly: err saturates.
    for (int i = 0; i < 300; i++) begin
      tick(1'b0, 1'b0, 12'h000);
      tick(1'b1, 1'b1, 12'h000);
      if (i == 99) chk("err_count_mid", err_count, exp_err + 100);
    end
    chk("err_count_sat", err_count, 255);

    // Relock, then reset in the middle of a frame and relock from SEARCH.
    run_frame(M_NORMAL, 0, 1'b0);
    run_frame(M_NORMAL, 0, 1'b0);
    run_frame(M_NORMAL, 1, 1'b0);
    run_frame(M_RST, 1, 1'b0);
    run_frame(M_NORMAL, 0, 1'b0);
    run_frame(M_NORMAL, 0, 1'b0);
    run_frame(M_NORMAL, 1, 1'b0);
    chk("post_rst_err_count", err_count, exp_err);
    chk("post_rst_frame_count", frame_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
